ide_pio_engine: RTL and testbench
=================================

Name: ide_pio_engine

Overview:
- Multi-channel IDE PIO cycle generator for the next-generation card; replaces the fixed-timing strobe logic in the IDE block.
- Sits between the Zorro II slave decode (autoconfig `ide_access`) and up to four IDE ports.
- Provides per-channel, software-selectable PIO timing modes 0-4, IORDY wait-state insertion with timeout, and a recovery interval between cycles.
- Owns DTACK generation for IDE accesses.

Parameters:
- CHANNELS, 2, number of IDE ports (1..4); each port has two chip-selects.
- TIMING_SCALE, 1, multiplier applied to every table count (set >1 for faster CLK).
- IORDY_TIMEOUT, 64, max CLK cycles ACTIVE may be extended by IORDY low.
- CNT_W, 8, width of phase/IORDY counters; must hold 3*TIMING_SCALE and IORDY_TIMEOUT.

Ports:
- CLK  in  1  7 MHz bus clock
- RESET  in  1  asynchronous, active-high reset
- ADDR  in  15  CPU address [15:1] within IDE window
- AS_n  in  1  address strobe
- UDS_n  in  1  upper data strobe
- LDS_n  in  1  lower data strobe
- RW  in  1  1=read
- DIN  in  3  DBUS[15:13], timing-mode write data
- ide_access  in  1  board window hit from autoconfig
- IORDY  in  1  OR of drive IORDY lines (1=ready)
- IOR_n  out  1  IDE read strobe
- IOW_n  out  1  IDE write strobe
- CS_n  out  2*CHANNELS  {chN CS1,chN CS0,...,ch0 CS1,ch0 CS0}
- DA  out  3  IDE register address
- DTACK  out  1  cycle acknowledge to bus logic (active high)
- busy  out  1  FSM not IDLE
- iordy_err  out  1  sticky: an IORDY timeout occurred

Behaviour:
- Address map:
  - ADDR[15:13] = channel field; ADDR[12] = CS select (0→CS0, 1→CS1); ADDR[4:2] → DA.
  - Channel field 7 = config space; ADDR[3:2] selects the target channel.
  - Channel field ≥ CHANNELS and ≠7: ignored (no strobe, no DTACK).
- Start condition, evaluated only in IDLE: !AS_n && ide_access && (!UDS_n || !LDS_n).
- Config write (RW=0): mode[ADDR[3:2]] ← DIN, with values 5-7 clamped to 4; a target ≥ CHANNELS is discarded.
  - Config read or write: DTACK asserted the next cycle, no IDE strobes, then go to WAITAS.
- Timing table (setup, active, recovery in CLK cycles, each ×TIMING_SCALE):
  - mode0 (1,3,2); mode1 (1,2,2); mode2 (1,2,1); mode3 (1,1,1); mode4 (1,1,0).
- FSM states: IDLE, SETUP, ACTIVE, ACK, WAITAS, RECOVER.
- IDLE:
  - On a valid IDE start, latch CS, DA, RW and the channel's mode, then go to SETUP.
  - CS_n(selected) and DA are driven from SETUP entry until RECOVER entry.
- SETUP: count setup cycles, then go to ACTIVE.
- ACTIVE:
  - IOR_n (read) or IOW_n (write) low.
  - Count the active cycles; at terminal count, if IORDY=1 go to ACK.
  - If IORDY=0, stay and count wait cycles; when the wait count reaches IORDY_TIMEOUT, set iordy_err and go to ACK anyway.
- ACK:
  - DTACK=1 and the strobe stays low while AS_n=0.
  - On AS_n=1: strobe, DTACK and CS_n release in the same edge, then go to RECOVER.
- Abort: AS_n rising in SETUP or ACTIVE → strobe and CS_n released next edge, no DTACK, go to RECOVER.
- RECOVER:
  - Count recovery cycles; a count of 0 goes straight to IDLE.
  - A start seen during RECOVER is held off (busy=1); it is accepted in IDLE only if AS_n is still low.
- WAITAS: wait for AS_n=1, then go to IDLE. A single AS_n assertion never starts two cycles.
- Reset values (async, any state):
  - IOR_n=1, IOW_n=1, CS_n=all 1, DA=0, DTACK=0, busy=0, iordy_err=0.
  - All mode registers 0; FSM in IDLE; counters 0.
- Reset mid-cycle releases all strobes immediately, with no glitch to the active level.
- iordy_err clears only on RESET.
- All outputs are registered; DTACK latency from AS_n fall = setup + active + 1 CLK for IORDY=1 (mode4, scale 1: 3 clocks).
- Never are both IOR_n and IOW_n low; never is more than one CS_n bit low.

Test Plan:
- Reset, then read ch0 CS0 DA=7 (ADDR=0x001C), mode0:
  - CS_n=0b1110 and DA=7 one clock after start; IOR_n low exactly 3 clocks before DTACK=1.
  - After AS_n rises, all outputs release and busy stays 1 for 2 clocks.
- Config write ADDR[15:13]=7, ADDR[3:2]=1, DIN=6:
  - Mode of ch1 reads back as 4 (clamped), checked by a ch1 write: IOW_n low 1 clock, no recovery cycles.
  - No strobe during the config cycle.
- ch1 CS1 read with IORDY held low 10 clocks then high:
  - ACTIVE stretched by 10 clocks; DTACK follows; iordy_err=0.
- IORDY stuck low, IORDY_TIMEOUT=64:
  - DTACK asserted after the timeout; iordy_err=1 and stays 1 across later cycles until RESET.
- AS_n deasserted during ACTIVE (bus error):
  - No DTACK; IOR_n/CS_n high next edge; RECOVER runs; next cycle starts normally.
- RESET pulsed during ACTIVE of a write:
  - IOW_n=1, CS_n all 1, busy=0 asynchronously.
  - Modes return to 0, verified by a subsequent 3-clock active strobe.

Source files
------------

// File: rtl/ide_pio_if.sv
// Bus-side signal bundle of the IDE PIO engine: Zorro II slave decode inputs,
// IDE port strobes/selects and the acknowledge/status returned to bus logic.
interface ide_pio_if #(
    parameter int CHANNELS = 2
);
    logic [15:1]           ADDR;
    logic                  AS_n;
    logic                  UDS_n;
    logic                  LDS_n;
    logic                  RW;
    logic [2:0]            DIN;
    logic                  ide_access;
    logic                  IORDY;
    logic                  IOR_n;
    logic                  IOW_n;
    logic [2*CHANNELS-1:0] CS_n;
    logic [2:0]            DA;
    logic                  DTACK;
    logic                  busy;
    logic                  iordy_err;

    modport master (
        output ADDR, AS_n, UDS_n, LDS_n, RW, DIN, ide_access, IORDY,
        input  IOR_n, IOW_n, CS_n, DA, DTACK, busy, iordy_err
    );

    modport slave (
        input  ADDR, AS_n, UDS_n, LDS_n, RW, DIN, ide_access, IORDY,
        output IOR_n, IOW_n, CS_n, DA, DTACK, busy, iordy_err
    );
endinterface

// File: rtl/ide_pio_engine.sv
// Multi-channel IDE PIO cycle generator: per-channel timing modes 0-4, IORDY
// wait insertion with timeout, recovery spacing and DTACK generation.
module ide_pio_engine #(
    parameter int CHANNELS      = 2,
    parameter int TIMING_SCALE  = 1,
    parameter int IORDY_TIMEOUT = 64,
    parameter int CNT_W         = 8
) (
    input  logic     CLK,
    input  logic     RESET,
    ide_pio_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        ACK,
        WAITAS,
        RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(TIMING_SCALE);
    localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(IORDY_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state;
    logic [2:0]       mode_r [CHANNELS];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] act_len;
    logic [CNT_W-1:0] rec_len;
    logic             rd;

    logic [2:0] ch;
    logic       start;
    logic       ch_valid;
    logic [2:0] sel_mode;
    logic       release_now;
    logic       unused_addr;

    function automatic logic [2:0] clamp_mode(input logic [2:0] d);
        return (d > 3'd4) ? 3'd4 : d;
    endfunction

    function automatic logic [CNT_W-1:0] act_len_f(input logic [2:0] m);
        int n;
        case (m)
            3'd0:       n = 3;
            3'd1, 3'd2: n = 2;
            default:    n = 1;
        endcase
        return CNT_W'(n * TIMING_SCALE);
    endfunction

    function automatic logic [CNT_W-1:0] rec_len_f(input logic [2:0] m);
        int n;
        case (m)
            3'd0, 3'd1: n = 2;
            3'd2, 3'd3: n = 1;
            default:    n = 0;
        endcase
        return CNT_W'(n * TIMING_SCALE);
    endfunction

    function automatic logic [2*CHANNELS-1:0] cs_pattern(input logic [2:0] c, input logic cs1);
        logic [2*CHANNELS-1:0] r;
        for (int i = 0; i < 2*CHANNELS; i++) begin
            r[i] = !((c == 3'(i / 2)) && (cs1 == 1'(i % 2)));
        end
        return r;
    endfunction

    assign ch          = bus.ADDR[15:13];
    assign start       = !bus.AS_n && bus.ide_access && (!bus.UDS_n || !bus.LDS_n);
    assign ch_valid    = (32'(ch) < 32'(CHANNELS));
    assign unused_addr = ^{bus.ADDR[11:5], bus.ADDR[1]};

    // Releasing the bus on AS_n high covers both the normal ACK exit and an abort.
    assign release_now = bus.AS_n && (state == SETUP || state == ACTIVE || state == ACK);

    always_comb begin
        sel_mode = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch == 3'(c)) sel_mode = mode_r[c];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            bus.IOR_n     <= 1'b1;
            bus.IOW_n     <= 1'b1;
            bus.CS_n      <= '1;
            bus.DA        <= '0;
            bus.DTACK     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.iordy_err <= 1'b0;
            cnt           <= '0;
            wait_cnt      <= '0;
            act_len       <= '0;
            rec_len       <= '0;
            rd            <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) mode_r[c] <= '0;
        end else if (release_now) begin
            bus.IOR_n <= 1'b1;
            bus.IOW_n <= 1'b1;
            bus.CS_n  <= '1;
            bus.DA    <= '0;
            bus.DTACK <= 1'b0;
            cnt       <= '0;
            if (rec_len == '0) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                state <= RECOVER;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start && ch == 3'd7) begin
                        if (!bus.RW) begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (bus.ADDR[3:2] == 2'(c)) mode_r[c] <= clamp_mode(bus.DIN);
                            end
                        end
                        bus.DTACK <= 1'b1;
                        bus.busy  <= 1'b1;
                        state     <= WAITAS;
                    end else if (start && ch_valid) begin
                        bus.CS_n <= cs_pattern(ch, bus.ADDR[12]);
                        bus.DA   <= bus.ADDR[4:2];
                        rd       <= bus.RW;
                        act_len  <= act_len_f(sel_mode);
                        rec_len  <= rec_len_f(sel_mode);
                        cnt      <= '0;
                        wait_cnt <= '0;
                        bus.busy <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LEN - ONE) begin
                        cnt   <= '0;
                        state <= ACTIVE;
                        if (rd) bus.IOR_n <= 1'b0;
                        else    bus.IOW_n <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ACTIVE: begin
                    // Wait cycles only accrue once the programmed active time is spent.
                    if (cnt != act_len - ONE) begin
                        cnt <= cnt + ONE;
                    end else if (bus.IORDY) begin
                        bus.DTACK <= 1'b1;
                        state     <= ACK;
                    end else if (wait_cnt == TIMEOUT) begin
                        bus.iordy_err <= 1'b1;
                        bus.DTACK     <= 1'b1;
                        state         <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt + ONE;
                    end
                end
                ACK: begin
                    state <= ACK;
                end
                RECOVER: begin
                    if (cnt == rec_len - ONE) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                WAITAS: begin
                    if (bus.AS_n) begin
                        bus.DTACK <= 1'b0;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ide_pio_engine.sv
// Directed bench for ide_pio_engine: mode timing, config writes with clamping,
// IORDY stretch and timeout, bus abort and asynchronous reset mid-cycle.
module tb_ide_pio_engine;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ide_pio_if #(.CHANNELS(2)) bus ();

    ide_pio_engine #(
        .CHANNELS(2),
        .TIMING_SCALE(1),
        .IORDY_TIMEOUT(64),
        .CNT_W(8)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cycle(input logic [15:0] byte_addr, input logic rw, input logic [2:0] din);
        bus.ADDR       = byte_addr[15:1];
        bus.RW         = rw;
        bus.DIN        = din;
        bus.ide_access = 1'b1;
        bus.UDS_n      = 1'b0;
        bus.LDS_n      = 1'b0;
        bus.AS_n       = 1'b0;
    endtask

    task automatic end_cycle();
        bus.AS_n       = 1'b1;
        bus.UDS_n      = 1'b1;
        bus.LDS_n      = 1'b1;
        bus.ide_access = 1'b0;
    endtask

    // Counts negedges with a strobe low until DTACK is seen; leaves caller on that negedge.
    task automatic wait_dtack(output int low);
        bit ok;
        low = 0;
        ok  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.DTACK) begin
                ok = 1;
                break;
            end
            if (!bus.IOR_n || !bus.IOW_n) low++;
        end
        check("dtack_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        int low;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.ADDR = '0;
        bus.RW = 1'b1;
        bus.DIN = '0;
        bus.IORDY = 1'b1;
        end_cycle();

        repeat (2) @(negedge clk);
        check("rst_ior", 32'(bus.IOR_n), 32'd1);
        check("rst_iow", 32'(bus.IOW_n), 32'd1);
        check("rst_cs", 32'(bus.CS_n), 32'hF);
        check("rst_da", 32'(bus.DA), 32'd0);
        check("rst_dtack", 32'(bus.DTACK), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.iordy_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ch0 CS0 read, DA=7, mode0 (1,3,2)
        start_cycle(16'h001C, 1'b1, 3'd0);
        @(negedge clk);
        check("m0_cs", 32'(bus.CS_n), 32'hE);
        check("m0_da", 32'(bus.DA), 32'd7);
        check("m0_busy", 32'(bus.busy), 32'd1);
        check("m0_setup_ior", 32'(bus.IOR_n), 32'd1);
        wait_dtack(low);
        check("m0_low", 32'(low), 32'd3);
        check("m0_ack_ior", 32'(bus.IOR_n), 32'd0);
        check("m0_ack_iow", 32'(bus.IOW_n), 32'd1);
        end_cycle();
        @(negedge clk);
        check("m0_rel_ior", 32'(bus.IOR_n), 32'd1);
        check("m0_rel_cs", 32'(bus.CS_n), 32'hF);
        check("m0_rel_dtack", 32'(bus.DTACK), 32'd0);
        check("m0_rec_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("m0_rec_busy2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("m0_idle_busy", 32'(bus.busy), 32'd0);

        // config write: ch1 mode <- 6, clamped to 4
        start_cycle(16'hE004, 1'b0, 3'd6);
        @(negedge clk);
        check("cfg_dtack", 32'(bus.DTACK), 32'd1);
        check("cfg_iow", 32'(bus.IOW_n), 32'd1);
        check("cfg_ior", 32'(bus.IOR_n), 32'd1);
        check("cfg_cs", 32'(bus.CS_n), 32'hF);
        end_cycle();
        @(negedge clk);
        check("cfg_dtack_off", 32'(bus.DTACK), 32'd0);
        check("cfg_busy_off", 32'(bus.busy), 32'd0);

        // ch1 CS0 write at mode4: 1 active clock, no recovery
        start_cycle(16'h2008, 1'b0, 3'd0);
        @(negedge clk);
        check("m4_cs", 32'(bus.CS_n), 32'hB);
        check("m4_da", 32'(bus.DA), 32'd2);
        wait_dtack(low);
        check("m4_low", 32'(low), 32'd1);
        check("m4_ack_iow", 32'(bus.IOW_n), 32'd0);
        check("m4_ack_ior", 32'(bus.IOR_n), 32'd1);
        end_cycle();
        @(negedge clk);
        check("m4_rel_iow", 32'(bus.IOW_n), 32'd1);
        check("m4_no_rec", 32'(bus.busy), 32'd0);

        // unimplemented channel 2: ignored
        start_cycle(16'h4000, 1'b1, 3'd0);
        repeat (3) @(negedge clk);
        check("ign_dtack", 32'(bus.DTACK), 32'd0);
        check("ign_busy", 32'(bus.busy), 32'd0);
        check("ign_cs", 32'(bus.CS_n), 32'hF);
        end_cycle();
        @(negedge clk);

        // ch1 CS1 read, IORDY low for 10 clocks past the active time
        bus.IORDY = 1'b0;
        start_cycle(16'h3000, 1'b1, 3'd0);
        @(negedge clk);
        check("wt_cs", 32'(bus.CS_n), 32'h7);
        @(negedge clk);
        check("wt_ior_low", 32'(bus.IOR_n), 32'd0);
        low = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.IOR_n && !bus.DTACK) low++;
        end
        bus.IORDY = 1'b1;
        begin
            int extra;
            wait_dtack(extra);
            low = low + extra;
        end
        check("wt_low", 32'(low), 32'd11);
        check("wt_err", 32'(bus.iordy_err), 32'd0);
        end_cycle();
        @(negedge clk);

        // IORDY stuck low: timeout after 64 extra clocks
        bus.IORDY = 1'b0;
        start_cycle(16'h2000, 1'b1, 3'd0);
        @(negedge clk);
        wait_dtack(low);
        check("to_low", 32'(low), 32'd65);
        check("to_err", 32'(bus.iordy_err), 32'd1);
        end_cycle();
        bus.IORDY = 1'b1;
        @(negedge clk);

        // abort during ACTIVE of a ch0 mode0 read
        start_cycle(16'h0000, 1'b1, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check("ab_ior_low", 32'(bus.IOR_n), 32'd0);
        end_cycle();
        @(negedge clk);
        check("ab_ior_rel", 32'(bus.IOR_n), 32'd1);
        check("ab_cs_rel", 32'(bus.CS_n), 32'hF);
        check("ab_no_dtack", 32'(bus.DTACK), 32'd0);
        check("ab_rec_busy", 32'(bus.busy), 32'd1);
        repeat (2) @(negedge clk);
        check("ab_idle", 32'(bus.busy), 32'd0);
        start_cycle(16'h0000, 1'b1, 3'd0);
        @(negedge clk);
        wait_dtack(low);
        check("ab_next_low", 32'(low), 32'd3);
        check("err_sticky", 32'(bus.iordy_err), 32'd1);
        end_cycle();
        repeat (3) @(negedge clk);

        // ch0 -> mode2, then reset during the ACTIVE phase of a write
        start_cycle(16'hE000, 1'b0, 3'd2);
        @(negedge clk);
        end_cycle();
        @(negedge clk);
        start_cycle(16'h0004, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check("rs_iow_low", 32'(bus.IOW_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rs_iow", 32'(bus.IOW_n), 32'd1);
        check("rs_cs", 32'(bus.CS_n), 32'hF);
        check("rs_busy", 32'(bus.busy), 32'd0);
        check("rs_err", 32'(bus.iordy_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        end_cycle();
        @(negedge clk);
        start_cycle(16'h0000, 1'b1, 3'd0);
        @(negedge clk);
        wait_dtack(low);
        check("rs_mode0_low", 32'(low), 32'd3);
        end_cycle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
